// File: rtl/uart_pkg.sv
// Shared UART receive definitions: default clock frequency and receiver FSM states.
// Combinational declarations only, so there is no latency and no backpressure.
package uart_pkg;

  localparam int CLK_FREQ_DEFAULT = 100_000_000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer; resets to 1, which is the idle level of the line.
// Latency is 2 clk cycles. There is no backpressure.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver; valid fires about 2+HALF+9*PERIOD+1 clk cycles after the start edge.
// There is no backpressure: data holds its value until the next good frame arrives.
module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_RATE = 9600,
  parameter int CLK_FREQ  = CLK_FREQ_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int PERIOD = CLK_FREQ / UART_RATE;
  localparam int HALF   = PERIOD / 2;
  localparam int CW     = $clog2(PERIOD) + 1;

  localparam logic [CW-1:0] P_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HALF - 1);

  logic           rs;
  uart_rx_state_t state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;

  uart_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (r),
    .q    (rs)
  );

  // cnt never passes P_LAST; every sampling state clears it when it reaches its limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rs) state <= START;
        end
        START: begin
          if (cnt == H_LAST) begin
            cnt   <= '0;
            state <= rs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == P_LAST) begin
            cnt            <= '0;
            shreg[bit_cnt] <= rs;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Deciding at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          if (cnt == P_LAST) begin
            cnt <= '0;
            if (rs) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at PERIOD=10 and HALF=5, using directed vectors and random frames.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int UART_RATE = 100_000;
  localparam int P = 10;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;

  uart_rx #(.UART_RATE(UART_RATE), .CLK_FREQ(CLK_FREQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r        (r),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vcnt = 0;
  int fcnt = 0;
  int t_fall = 0;
  int t_valid = 0;
  bit prev_pulse = 1'b0;

  typedef struct {
    string      name;
    logic [7:0] b;
    int         stop_cycles;
    logic       stop_val;
    int         gap;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      vcnt++;
      t_valid = cyc;
    end
    if (frame_err) fcnt++;
    if (valid || frame_err)
      chk("pulse_excl", int'((valid && frame_err) || prev_pulse), 0);
    prev_pulse = valid || frame_err;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input int stop_cycles, input logic stop_val,
                      input int gap);
    r = 1'b0;
    t_fall = cyc;
    ticks(P);
    for (int i = 0; i < 8; i++) begin
      r = b[i];
      ticks(P);
    end
    r = stop_val;
    ticks(stop_cycles);
    r = 1'b1;
    ticks(gap);
  endtask

  initial begin
    int v0, f0, lat, nexp_v, nexp_f;
    logic [7:0] exp_d, rb, b5a;
    bit good;
    int sc, gp;

    vecs[0] = '{"a5",       8'hA5, P,     1'b1, 4, 1, 0, 8'hA5};
    vecs[1] = '{"3c_badst", 8'h3C, 3 * P, 1'b0, 4, 0, 1, 8'hA5};
    vecs[2] = '{"81",       8'h81, P,     1'b1, 4, 1, 0, 8'h81};
    vecs[3] = '{"b2b_00",   8'h00, P,     1'b1, 0, 1, 0, 8'h00};
    vecs[4] = '{"b2b_ff",   8'hFF, P,     1'b1, 4, 1, 0, 8'hFF};
    vecs[5] = '{"7e",       8'h7E, P,     1'b1, 6, 1, 0, 8'h7E};

    // Reset state
    ticks(3);
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ferr", int'(frame_err), 0);
    rst_n = 1'b1;
    ticks(4);

    // Directed vectors
    foreach (vecs[k]) begin
      v0 = vcnt;
      f0 = fcnt;
      send(vecs[k].b, vecs[k].stop_cycles, vecs[k].stop_val, vecs[k].gap);
      chk({vecs[k].name, "_valid"}, vcnt - v0, vecs[k].exp_v);
      chk({vecs[k].name, "_ferr"}, fcnt - f0, vecs[k].exp_f);
      chk({vecs[k].name, "_data"}, int'(data), int'(vecs[k].exp_d));
    end

    // A short low glitch on the line must be rejected
    v0 = vcnt;
    f0 = fcnt;
    r = 1'b0;
    ticks(3);
    r = 1'b1;
    ticks(H + 3);
    chk("glitch_idle", int'(dut.state == uart_pkg::IDLE), 1);
    ticks(2 * P);
    chk("glitch_pulses", (vcnt - v0) + (fcnt - f0), 0);
    chk("glitch_data", int'(data), 8'h7E);

    // Latency from the falling edge of r to valid
    v0 = vcnt;
    send(8'h01, P, 1'b1, 4);
    lat = t_valid - t_fall;
    chk("latency", (lat >= 97 && lat <= 99) ? 98 : lat, 98);
    chk("lat_valid", vcnt - v0, 1);
    chk("lat_data", int'(data), 8'h01);

    // Reset during bit 4 of 8'h5A; the line returns to idle together with the reset
    b5a = 8'h5A;
    v0 = vcnt;
    f0 = fcnt;
    r = 1'b0;
    ticks(P);
    for (int i = 0; i < 4; i++) begin
      r = b5a[i];
      ticks(P);
    end
    r = b5a[4];
    ticks(H);
    rst_n = 1'b0;
    #1;
    chk("rst_async_data", int'(data), 0);
    chk("rst_async_valid", int'(valid), 0);
    r = 1'b1;
    ticks(3);
    rst_n = 1'b1;
    ticks(12 * P);
    chk("rst_mid_pulses", (vcnt - v0) + (fcnt - f0), 0);
    chk("rst_mid_data", int'(data), 0);
    v0 = vcnt;
    send(8'hC3, P, 1'b1, 4);
    chk("c3_valid", vcnt - v0, 1);
    chk("c3_data", int'(data), 8'hC3);

    // Random frames checked against a frame-level reference model
    exp_d = 8'hC3;
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      sc   = good ? P : int'($urandom_range(P, 4 * P));
      gp   = good ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12));
      nexp_v = good ? 1 : 0;
      nexp_f = good ? 0 : 1;
      if (good) exp_d = rb;
      v0 = vcnt;
      f0 = fcnt;
      send(rb, sc, good, gp);
      chk("rnd_valid", vcnt - v0, nexp_v);
      chk("rnd_ferr", fcnt - f0, nexp_f);
      chk("rnd_data", int'(data), int'(exp_d));
    end

    ticks(2 * P);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
